// File: rtl/aes_output_serializer.sv
// Result-side serializer for the AES datapath: buffers 128-bit result blocks
// from the core and streams them out as four 32-bit words over valid/ready.
module aes_output_serializer #(
  parameter int DEPTH     = 2,
  parameter bit LSW_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done_i,
  input  logic [127:0] text_i,
  output logic         ready_o,
  output logic [31:0]  text_o,
  output logic         valid_o,
  output logic         last_o,
  input  logic         ready_i,
  output logic         ovf_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  // Fill level decoded from count; there is no separate state register.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [127:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [1:0]    word_idx;
  logic          ovf;

  logic [1:0]    fill_state;
  logic          pop;
  logic          pop_last;
  logic          slot_free;
  logic          wr_en;
  logic [127:0]  head;
  logic [1:0]    sel;

  always_comb begin
    fill_state = ST_PARTIAL;
    if (count == '0) begin
      fill_state = ST_EMPTY;
    end else if (count == DEPTH_C) begin
      fill_state = ST_FULL;
    end
  end

  // Handshake: a word moves on every cycle with valid_o && ready_i; while
  // valid_o is high and ready_i low, text_o and last_o hold their values.
  assign valid_o   = (fill_state != ST_EMPTY);
  assign ready_o   = (fill_state != ST_FULL);
  assign pop       = valid_o && ready_i;
  assign pop_last  = pop && (word_idx == 2'd3);
  assign slot_free = ready_o || pop_last;
  assign wr_en     = done_i && slot_free;

  assign head   = mem[rd_ptr];
  assign sel    = LSW_FIRST ? word_idx : ~word_idx;
  assign text_o = head[{sel, 5'd0} +: 32];
  assign last_o = valid_o && (word_idx == 2'd3);
  assign ovf_o  = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_idx <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= text_i;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (done_i && !slot_free) begin
        ovf <= 1'b1;
      end
      if (pop) begin
        word_idx <= word_idx + 2'd1;
      end
      if (pop_last) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, pop_last})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_output_serializer.sv
// Directed bench for aes_output_serializer: one instance per word order,
// with a word scoreboard per instance and immediate-assertion checks.
module tb_aes_output_serializer;

  localparam logic [127:0] BLK1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_A = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] BLK_B = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] BLK_C = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] BLK_D = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
  localparam logic [127:0] BLK_E = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;
  localparam logic [127:0] BLK_F = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;

  logic         clk;
  logic         rst;
  logic         done_i, done1;
  logic [127:0] text_i, text1;
  logic         ready_i, ready1;
  logic         ready_o, ready_o1;
  logic [31:0]  text_o, text_o1;
  logic         valid_o, valid_o1;
  logic         last_o, last_o1;
  logic         ovf_o, ovf_o1;

  int vectors;
  int miscompares;

  // scoreboard entries are {last, word}
  logic [32:0] exp_q[$];
  logic [32:0] exp1_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_output_serializer #(.DEPTH(2), .LSW_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .done_i(done_i), .text_i(text_i),
    .ready_o(ready_o), .text_o(text_o), .valid_o(valid_o),
    .last_o(last_o), .ready_i(ready_i), .ovf_o(ovf_o)
  );

  aes_output_serializer #(.DEPTH(2), .LSW_FIRST(1'b0)) dut_msw (
    .clk(clk), .rst(rst), .done_i(done1), .text_i(text1),
    .ready_o(ready_o1), .text_o(text_o1), .valid_o(valid_o1),
    .last_o(last_o1), .ready_i(ready1), .ovf_o(ovf_o1)
  );

  // ---------------- checker / scoreboard ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_lsw(input logic [127:0] blk);
    exp_q.push_back({1'b0, blk[31:0]});
    exp_q.push_back({1'b0, blk[63:32]});
    exp_q.push_back({1'b0, blk[95:64]});
    exp_q.push_back({1'b1, blk[127:96]});
  endtask

  task automatic push_msw(input logic [127:0] blk);
    exp1_q.push_back({1'b0, blk[127:96]});
    exp1_q.push_back({1'b0, blk[95:64]});
    exp1_q.push_back({1'b0, blk[63:32]});
    exp1_q.push_back({1'b1, blk[31:0]});
  endtask

  // Check the head word of each instance, retire it on a handshake, then
  // advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("lsw_unexpected_valid", valid_o, 1'b0);
      end else begin
        check("lsw_word", text_o, exp_q[0][31:0]);
        check("lsw_last", last_o, exp_q[0][32]);
        if (ready_i) void'(exp_q.pop_front());
      end
    end
    if (valid_o1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        check("msw_unexpected_valid", valid_o1, 1'b0);
      end else begin
        check("msw_word", text_o1, exp1_q[0][31:0]);
        check("msw_last", last_o1, exp1_q[0][32]);
        if (ready1) void'(exp1_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; done_i = 1'b0; ready_i = 1'b0; done1 = 1'b0; ready1 = 1'b0;
    tick();
    exp_q.delete();
    exp1_q.delete();
    rst = 1'b0;
  endtask

  task automatic send(input logic [127:0] blk);
    push_lsw(blk);
    done_i = 1'b1; text_i = blk;
    tick();
    done_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] w_lsw [4];
    logic        pat [7];
    int          n_acc;
    logic [127:0] blks [5];

    vectors = 0; miscompares = 0;
    rst = 1'b1; done_i = 1'b0; text_i = '0; ready_i = 1'b0;
    done1 = 1'b0; text1 = '0; ready1 = 1'b0;
    w_lsw = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    blks  = '{BLK1, BLK_A, BLK_B, BLK_C, BLK_D};

    @(posedge clk); #1;
    do_reset();
    check("rst_valid", valid_o, 1'b0);
    check("rst_last", last_o, 1'b0);
    check("rst_ready", ready_o, 1'b1);
    check("rst_ovf", ovf_o, 1'b0);
    check("rst_text", text_o, 32'h0);
    check("rst_valid_msw", valid_o1, 1'b0);

    // single block, LSW first, ready held high
    ready_i = 1'b1;
    send(BLK1);
    for (int i = 0; i < 4; i++) begin
      check("single_valid", valid_o, 1'b1);
      check("single_text", text_o, w_lsw[i]);
      check("single_last", last_o, (i == 3));
      check("single_ready", ready_o, 1'b1);
      tick();
    end
    check("single_valid_drop", valid_o, 1'b0);

    // backpressure pattern 1,0,0,1,0,1,1
    ready_i = 1'b0;
    send(BLK1);
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      if (n_acc < 4) check("bp_valid_held", valid_o, 1'b1);
      ready_i = pat[i];
      if (pat[i]) n_acc++;
      tick();
    end
    ready_i = 1'b0;
    check("bp_valid_drop", valid_o, 1'b0);
    check("bp_sb_empty", exp_q.size(), 0);

    // fill to DEPTH with ready low, then overflow with C
    send(BLK_A);
    check("fill_ready_after_a", ready_o, 1'b1);
    send(BLK_B);
    check("fill_ready_after_b", ready_o, 1'b0);
    check("fill_ovf_before_c", ovf_o, 1'b0);
    done_i = 1'b1; text_i = BLK_C;
    tick();
    done_i = 1'b0;
    check("ovf_after_c", ovf_o, 1'b1);
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("ovf_sticky", ovf_o, 1'b1);
    check("ovf_drain_valid", valid_o, 1'b0);
    check("ovf_sb_empty", exp_q.size(), 0);

    do_reset();
    check("rst2_ovf", ovf_o, 1'b0);
    check("rst2_ready", ready_o, 1'b1);

    // full buffer, write D on the same edge as the head block's last pop
    send(BLK_A);
    send(BLK_B);
    check("full_ready", ready_o, 1'b0);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("full_head_last", last_o, 1'b1);
    send(BLK_D);
    check("full_pop_ovf", ovf_o, 1'b0);
    check("full_pop_ready", ready_o, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("full_pop_valid_drop", valid_o, 1'b0);
    check("full_pop_ovf_end", ovf_o, 1'b0);
    check("full_pop_sb_empty", exp_q.size(), 0);

    // reset after word 1 of a block
    ready_i = 1'b1;
    send(BLK_E);
    tick();
    tick();
    check("mid_word2_pending", text_o, 32'hE4E5E6E7);
    do_reset();
    check("mid_rst_valid", valid_o, 1'b0);
    check("mid_rst_ready", ready_o, 1'b1);
    check("mid_rst_ovf", ovf_o, 1'b0);
    check("mid_rst_last", last_o, 1'b0);
    ready_i = 1'b1;
    send(BLK_F);
    check("fresh_word0", text_o, 32'hFCFDFEFF);
    check("fresh_last0", last_o, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("fresh_valid_drop", valid_o, 1'b0);
    ready_i = 1'b0;

    // MSW-first instance: 5 blocks at 4-cycle spacing, wraps both pointers
    ready1 = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) begin
        if (b != 0 || w != 0) check("msw_no_bubble", valid_o1, 1'b1);
        if (w == 0) push_msw(blks[b]);
        done1 = (w == 0);
        text1 = blks[b];
        tick();
        if (b == 0 && w == 0) check("msw_first_word", text_o1, 32'h00112233);
      end
    end
    done1 = 1'b0;
    check("msw_ovf", ovf_o1, 1'b0);
    tick();
    check("msw_valid_drop", valid_o1, 1'b0);
    check("msw_sb_empty", exp1_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_output_serializer.md
# aes_output_serializer

Result-side stage of the AES datapath: captures each 128-bit result block produced by the AES core on its completion pulse and returns it as four 32-bit words over a valid/ready stream. Mirrors the 32-bit word interface of the load side: least-significant word first by default. A small block FIFO decouples the core from a stalling consumer. Dropped blocks are flagged rather than silently lost.

## Interface
- DEPTH, 2, number of 128-bit result blocks buffered; power of two, ≥ 2.
- LSW_FIRST, 1, 1: emit bits [31:0] first, then [63:32], [95:64], [127:96]; 0: reverse order.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- done_i  input  1  core result-valid pulse; text_i is sampled on any cycle with done_i=1.
- text_i  input  128  result block from the core.
- ready_o  output  1  block slot available (combinational: count < DEPTH).
- text_o  output  32  current output word.
- valid_o  output  1  text_o holds a valid word.
- last_o  output  1  current word is the 4th word of its block; qualified by valid_o.
- ready_i  input  1  downstream accepts text_o when valid_o && ready_i.
- ovf_o  output  1  sticky: a done_i pulse was dropped.

## Operation
- Storage: DEPTH × 128-bit circular buffer, write pointer, read pointer, block count 0..DEPTH, word index 0..3.
- Write: on a done_i cycle, if a slot is free, text_i is stored at the write pointer, the write pointer advances (wraps mod DEPTH), and count increments.
- A slot is free if count < DEPTH, or if count = DEPTH and the final word of the head block pops in the same cycle. In that second case, count is unchanged.
- Drop: done_i with no free slot leaves the buffer unchanged and sets ovf_o=1. ovf_o clears only on rst.
- Read: valid_o = (count > 0). text_o is the word selected by word index from the head block, mapped through LSW_FIRST. last_o = valid_o && (word index = 3).
- Pop: on each valid_o && ready_i cycle, word index increments. On word 3, word index returns to 0, the read pointer advances (wraps), and count decrements, unless a simultaneous write occurs, in which case count is held.
- Simultaneous write and pop with count between 0 and DEPTH exclusive: both take effect, count unchanged.
- ready_i with valid_o=0: no effect. valid_o stays high until its word is accepted. text_o and last_o are stable while valid_o && !ready_i.
- States implied by count: EMPTY (0), PARTIAL, FULL (DEPTH). There is no separate FSM register.

## Timing
- Reset: any clock edge with rst=1 sets count=0, pointers=0, word index=0, and ovf_o=0. done_i and ready_i are ignored on that edge.
- After reset: valid_o=0, last_o=0, ready_o=1, ovf_o=0. text_o is the 32-bit field of slot 0 selected by word index 0; it is don't-care while valid_o=0 but must be X-free (storage reset to 0).
- Latency: done_i sampled at edge N into an empty buffer gives valid_o=1 with word 0 in the cycle after edge N.
- With ready_i held at 1, one word transfers per cycle. A block streams in 4 cycles; back-to-back blocks stream with no bubble.
- Minimum done_i spacing for lossless operation with ready_i=1: 4 cycles sustained, or DEPTH blocks in a burst.
- Reset mid-block: the partial block and all buffered blocks are discarded. The next output after reset starts at word 0 of the next captured block.

## Test plan
- Single block, LSW_FIRST=1: text_i=0x00112233_44556677_8899AABB_CCDDEEFF with one done_i pulse and ready_i=1. Required: valid_o high for exactly 4 cycles starting the cycle after done_i. text_o = CCDDEEFF, 8899AABB, 44556677, 00112233. last_o=1 only on the 4th word. ready_o is 1 throughout.
- Backpressure: same block with ready_i toggling 1,0,0,1,0,1,1. Required: each word is held stable while stalled, exactly 4 transfers occur, order is unchanged, and valid_o drops after the 4th accepted word.
- Fill and overflow, DEPTH=2, ready_i=0: three done_i pulses with blocks A, B, C. Required: ready_o=0 after B, C is dropped, and ovf_o=1 from the cycle after C. Raising ready_i then streams 8 words, A then B, and ovf_o stays 1.
- Full plus simultaneous final pop: buffer full, with done_i for block D in the same cycle word 3 of the head block is accepted. Required: D is stored, ovf_o stays 0, and the output order is preserved, with D after the remaining block.
- Reset mid-stream: assert rst for 1 cycle after word 1 of a block. Required: the next cycle has valid_o=0, ready_o=1, and ovf_o=0. A fresh block then emits from word 0.
- LSW_FIRST=0: the block from the first scenario emits 00112233, 44556677, 8899AABB, CCDDEEFF, with pointer wrap exercised over 5 consecutive blocks.
